apb_bridge_nslv: RTL



---
 rtl/apb_pkg.sv | 20 ++
 rtl/apb_addr_decoder.sv | 22 ++
 rtl/apb_bridge_nslv.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// Shared types for the APB bridge: FSM states and typed response errors.
package apb_pkg;

  localparam int ERR_TYPE_W = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DERR   = 2'd3
  } state_t;

  typedef enum logic [ERR_TYPE_W-1:0] {
    NONE    = 2'd0,
    SLVERR  = 2'd1,
    DECODE  = 2'd2,
    TIMEOUT = 2'd3
  } err_type_t;

endpackage

// File: rtl/apb_addr_decoder.sv
// Region-field decoder: slave index, hit flag and one-hot select from the upper address bits.
module apb_addr_decoder #(
  parameter int NUM_SLV = 4,
  parameter int IDX_W   = 4
) (
  input  logic [IDX_W-1:0]   region,
  output logic [IDX_W-1:0]   idx,
  output logic               hit,
  output logic [NUM_SLV-1:0] sel
);

  assign idx = region;
  assign hit = (32'(region) < 32'(NUM_SLV));

  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      sel[i] = hit && (32'(region) == 32'(i));
    end
  end

endmodule

// File: rtl/apb_bridge_nslv.sv
// Single-transfer request port to NUM_SLV APB3 slaves with typed error responses.
// Optional APB4 write strobes when APB_PSTRB_EN is defined.
//
// state  | meaning
// IDLE   | ready for a request; latches command on REQ_VALID
// SETUP  | PSEL asserted, PENABLE low, timeout counter cleared
// ACCESS | PSEL+PENABLE, waiting for selected PREADY or timeout
// DERR   | decode miss (or empty strobe write); no bus cycle
module apb_bridge_nslv
  import apb_pkg::*;
#(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 32,
  parameter int NUM_SLV      = 4,
  parameter int SLV_ADDR_LSB = 12,
  parameter int TIMEOUT_CYC  = 16
) (
  input  logic                      PCLK,
  input  logic                      PRESETn,
  input  logic                      REQ_VALID,
  output logic                      REQ_READY,
  input  logic                      REQ_WRITE,
  input  logic [ADDR_W-1:0]         REQ_ADDR,
  input  logic [DATA_W-1:0]         REQ_WDATA,
`ifdef APB_PSTRB_EN
  input  logic [DATA_W/8-1:0]       REQ_STRB,
  output logic [DATA_W/8-1:0]       PSTRB,
`endif
  output logic                      RSP_VALID,
  output logic [DATA_W-1:0]         RSP_RDATA,
  output logic                      RSP_ERR,
  output logic [ERR_TYPE_W-1:0]     RSP_ERR_TYPE,
  output logic [NUM_SLV-1:0]        PSEL,
  output logic                      PENABLE,
  output logic                      PWRITE,
  output logic [ADDR_W-1:0]         PADDR,
  output logic [DATA_W-1:0]         PWDATA,
  input  logic [NUM_SLV-1:0]        PREADY,
  input  logic [NUM_SLV*DATA_W-1:0] PRDATA,
  input  logic [NUM_SLV-1:0]        PSLVERR
);

  localparam int IDX_W = ADDR_W - SLV_ADDR_LSB;
  localparam int CNT_W = $clog2(TIMEOUT_CYC);

  state_t              state_q, state_d;
  logic                pwrite_q;
  logic [ADDR_W-1:0]   paddr_q;
  logic [DATA_W-1:0]   pwdata_q;
  logic [IDX_W-1:0]    idx_q;
  logic [NUM_SLV-1:0]  sel_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                rsp_valid_q;
  err_type_t           rsp_err_q;
  logic [DATA_W-1:0]   rsp_rdata_q;

  logic [IDX_W-1:0]    dec_idx;
  logic                dec_hit;
  logic [NUM_SLV-1:0]  dec_sel;
  logic                strb_bad;
  logic                accept;
  logic                sel_ready;
  logic                sel_err;
  logic                timeout_hit;
  logic [DATA_W-1:0]   sel_rdata;

  apb_addr_decoder #(
    .NUM_SLV (NUM_SLV),
    .IDX_W   (IDX_W)
  ) u_dec (
    .region (REQ_ADDR[ADDR_W-1:SLV_ADDR_LSB]),
    .idx    (dec_idx),
    .hit    (dec_hit),
    .sel    (dec_sel)
  );

`ifdef APB_PSTRB_EN
  logic [DATA_W/8-1:0] pstrb_q;

  assign strb_bad = REQ_WRITE && (REQ_STRB == '0);
  assign PSTRB    = pwrite_q ? pstrb_q : '0;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn)    pstrb_q <= '0;
    else if (accept) pstrb_q <= REQ_STRB;
  end
`else
  assign strb_bad = 1'b0;
`endif

  assign accept = (state_q == IDLE) && REQ_VALID;

  // Masking with the latched select keeps unselected (possibly X) slave inputs out.
  assign sel_ready   = |(PREADY & sel_q);
  assign sel_err     = |(PSLVERR & sel_q);
  assign sel_rdata   = PRDATA[32'(idx_q)*DATA_W +: DATA_W];
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (REQ_VALID) state_d = (dec_hit && !strb_bad) ? SETUP : DERR;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (sel_ready || timeout_hit) state_d = IDLE;
      DERR:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    REQ_READY = 1'b0;
    PSEL      = '0;
    PENABLE   = 1'b0;
    case (state_q)
      IDLE:    REQ_READY = 1'b1;
      SETUP:   PSEL = sel_q;
      ACCESS: begin
        PSEL    = sel_q;
        PENABLE = 1'b1;
      end
      default: ;
    endcase
  end

  // Idx/select only latch on a hit so the read-data slice is always in range.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      pwrite_q <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      idx_q    <= '0;
      sel_q    <= '0;
    end else if (accept) begin
      pwrite_q <= REQ_WRITE;
      paddr_q  <= REQ_ADDR;
      pwdata_q <= REQ_WDATA;
      if (dec_hit) begin
        idx_q <= dec_idx;
        sel_q <= dec_sel;
      end
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn)                cnt_q <= '0;
    else if (state_q == SETUP)   cnt_q <= '0;
    else if (state_q == ACCESS)  cnt_q <= cnt_q + 1'b1;
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= NONE;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= NONE;
      rsp_rdata_q <= '0;
      if (state_q == ACCESS && sel_ready) begin
        rsp_valid_q <= 1'b1;
        rsp_err_q   <= sel_err ? SLVERR : NONE;
        if (!pwrite_q && !sel_err) rsp_rdata_q <= sel_rdata;
      end else if (state_q == ACCESS && timeout_hit) begin
        rsp_valid_q <= 1'b1;
        rsp_err_q   <= TIMEOUT;
      end else if (state_q == DERR) begin
        rsp_valid_q <= 1'b1;
        rsp_err_q   <= DECODE;
      end
    end
  end

  assign PWRITE       = pwrite_q;
  assign PADDR        = paddr_q;
  assign PWDATA       = pwdata_q;
  assign RSP_VALID    = rsp_valid_q;
  assign RSP_RDATA    = rsp_rdata_q;
  assign RSP_ERR_TYPE = rsp_err_q;
  assign RSP_ERR      = (rsp_err_q != NONE);

endmodule
